// File: rtl/srl_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : srl_chk_pkg
//  Description : Shared types, constants and helpers for the SRL shift
//                checker: FSM state encoding, stimulus LFSR polynomial,
//                tap-address arithmetic and width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package srl_chk_pkg;

    // Stimulus LFSR width and Fibonacci feedback taps.
    // x^16+x^14+x^13+x^11+1 in right-shift form feeds back bits 0,2,3,5.
    localparam int          LFSR_WIDTH    = 16;
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    // Supported parameter ranges.
    localparam int MIN_DEPTH    = 16;
    localparam int MAX_DEPTH    = 128;
    localparam int MAX_CHANNELS = 16;

    // Two-state controller: fill the delay lines, then check forever.
    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_CHECK = 1'b1
    } chk_state_t;

    // Next LFSR state: shift right, feedback enters at the MSB.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {^(s & LFSR_TAP_MASK), s[LFSR_WIDTH-1:1]};
    endfunction

    // Tap address of a lane: fixed per-lane spacing plus optional sweep base.
    function automatic int unsigned tap_addr(
        input int unsigned offset,
        input int unsigned lane,
        input int unsigned stride,
        input int unsigned base,
        input logic        sweep,
        input int unsigned depth
    );
        return (offset + lane * stride + (sweep ? base : 32'd0)) % depth;
    endfunction

endpackage : srl_chk_pkg
`default_nettype wire

// File: rtl/srl_chk_lane.sv
`default_nettype none
// ============================================================================
//  Module      : srl_chk_lane
//  Description : One checker lane. The stimulus bit (optionally inverted)
//                shifts through an unreset SRL-style line; the clean bit
//                shifts through a resettable flip-flop reference line. Both
//                are tapped at the same address and the difference is
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_chk_lane #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     d,
    input  logic                     inject,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic                     mismatch
);

    logic [DEPTH-1:0] r_srl;
    logic [DEPTH-1:0] r_ref;
    logic             w_dut_q;
    logic             w_ref_q;
    logic             r_mismatch;

    // Device-under-test line: no reset, so it maps onto shift-register LUTs.
    always_ff @(posedge clk) begin
        if (en) begin
            r_srl <= {r_srl[DEPTH-2:0], d ^ inject};
        end
    end

    // Reference line in plain flip-flops, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ref <= '0;
        end else if (en) begin
            r_ref <= {r_ref[DEPTH-2:0], d};
        end
    end

    // Shared combinational tap so address changes affect both lines at once.
    always_comb begin
        w_dut_q = r_srl[addr];
        w_ref_q = r_ref[addr];
    end

    // Registered compare, advancing only with the lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mismatch <= 1'b0;
        end else if (en) begin
            r_mismatch <= w_dut_q ^ w_ref_q;
        end
    end

    assign mismatch = r_mismatch;

endmodule : srl_chk_lane
`default_nettype wire

// File: rtl/srl_shift_checker.sv
`default_nettype none
// ============================================================================
//  Module      : srl_shift_checker
//  Description : Parametrised self-checking shift-register test block.
//                Drives CHANNELS lanes from a shared LFSR, sequences a
//                fill/check controller, sweeps the tap base in sweep mode
//                and accumulates sticky per-lane error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_shift_checker
    import srl_chk_pkg::*;
#(
    parameter int          CHANNELS     = 8,
    parameter int          DEPTH        = 32,
    parameter int          TAP_STRIDE   = 3,
    parameter int          TAP_OFFSET   = 0,
    parameter int          SWEEP_PERIOD = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [CHANNELS-1:0]      inject,
    output logic [CHANNELS-1:0]      error,
    output logic                     checking,
    output logic [$clog2(DEPTH)-1:0] tap_base
);

    localparam int AW  = $clog2(DEPTH);
    // Fill counter must hold the value DEPTH.
    localparam int FCW = $clog2(DEPTH + 2);
    localparam int SCW = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;

    logic [LFSR_WIDTH-1:0] r_lfsr;
    chk_state_t            r_state;
    logic                  r_checking;
    logic [FCW-1:0]        r_fill_cnt;
    logic [SCW-1:0]        r_sweep_cnt;
    logic [AW-1:0]         r_tap_base;
    logic [CHANNELS-1:0]   r_sticky;
    logic [CHANNELS-1:0]   w_mismatch;

    // Stimulus generator, advancing once per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Fill/check controller: DEPTH edges refill every line position, the
    // extra edge lets the compare register capture a fully refilled tap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_checking <= 1'b0;
            r_fill_cnt <= '0;
        end else if (en) begin
            case (r_state)
                ST_FILL: begin
                    if (r_fill_cnt == FCW'(DEPTH)) begin
                        r_state    <= ST_CHECK;
                        r_checking <= 1'b1;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + FCW'(1);
                    end
                end
                ST_CHECK: begin
                    r_checking <= 1'b1;
                end
                default: begin
                    r_state    <= ST_FILL;
                    r_checking <= 1'b0;
                end
            endcase
        end
    end

    // Tap-base sweep: one step every SWEEP_PERIOD enabled cycles in sweep mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sweep_cnt <= '0;
            r_tap_base  <= '0;
        end else if (en && mode && (r_state == ST_CHECK)) begin
            if (r_sweep_cnt == SCW'(SWEEP_PERIOD - 1)) begin
                r_sweep_cnt <= '0;
                r_tap_base  <= r_tap_base + AW'(1);
            end else begin
                r_sweep_cnt <= r_sweep_cnt + SCW'(1);
            end
        end
    end

    // Sticky capture of armed mismatches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (en && r_checking) begin
            r_sticky <= r_sticky | w_mismatch;
        end
    end

    // A registered mismatch shows on error in the same cycle it is captured.
    assign error    = r_sticky | (w_mismatch & {CHANNELS{r_checking}});
    assign checking = r_checking;
    assign tap_base = r_tap_base;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic [AW-1:0] w_addr;

        assign w_addr = AW'(tap_addr(32'(TAP_OFFSET), 32'(i), 32'(TAP_STRIDE),
                                     32'(r_tap_base), mode, 32'(DEPTH)));

        srl_chk_lane #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .d        (r_lfsr[i % LFSR_WIDTH]),
            .inject   (inject[i]),
            .addr     (w_addr),
            .mismatch (w_mismatch[i])
        );
    end

endmodule : srl_shift_checker
`default_nettype wire

// File: tb/tb_srl_shift_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srl_shift_checker
//  Description : Scoreboard bench for two checker configurations (8x32 and
//                16x128). A reference model tracks where injected faults sit
//                in each lane's history and predicts error/checking/tap_base.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_shift_checker;

    localparam int NI     = 2;
    localparam int SWEEP  = 64;
    localparam int STRIDE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [15:0] inject;

    logic [7:0]  err_a;
    logic        chk_a;
    logic [4:0]  base_a;
    logic [15:0] err_b;
    logic        chk_b;
    logic [6:0]  base_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    srl_shift_checker u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .inject   (inject[7:0]),
        .error    (err_a),
        .checking (chk_a),
        .tap_base (base_a)
    );

    srl_shift_checker #(
        .CHANNELS (16),
        .DEPTH    (128)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .inject   (inject),
        .error    (err_b),
        .checking (chk_b),
        .tap_base (base_b)
    );

    // ---------------- reference model ----------------
    // hist[k][lane][age]: 1 where the bit shifted in (age+1) enabled edges ago
    // was corrupted. Expected outputs come from fault positions and edge counts.
    bit hist   [NI][16][128];
    bit mreg   [NI][16];
    bit sticky [NI][16];
    int en_cnt [NI];
    int sw_cnt [NI];

    typedef struct packed {
        logic [7:0]  err_a;
        logic        chk_a;
        logic [4:0]  base_a;
        logic [15:0] err_b;
        logic        chk_b;
        logic [6:0]  base_b;
    } exp_t;

    exp_t expq[$];

    function automatic int dep(input int k);
        return (k == 0) ? 32 : 128;
    endfunction

    function automatic int nch(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic void model_edge(input int k);
        int  d;
        int  base;
        int  addr;
        bit  armed;
        d = dep(k);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mreg[k][i]   = 1'b0;
                sticky[k][i] = 1'b0;
                for (int p = 0; p < 128; p++) hist[k][i][p] = 1'b0;
            end
            en_cnt[k] = 0;
            sw_cnt[k] = 0;
            return;
        end
        if (!en) return;
        armed = (en_cnt[k] >= d + 1);
        base  = (sw_cnt[k] / SWEEP) % d;
        for (int i = 0; i < nch(k); i++) begin
            addr = (i * STRIDE + (mode ? base : 0)) % d;
            sticky[k][i] = sticky[k][i] | (mreg[k][i] & armed);
            // Positions not yet refilled since reset hold unknown data; they
            // only matter before checking is armed.
            mreg[k][i] = (addr < en_cnt[k]) ? hist[k][i][addr] : 1'b0;
            for (int p = d - 1; p > 0; p--) hist[k][i][p] = hist[k][i][p-1];
            hist[k][i][0] = inject[i];
        end
        if (en_cnt[k] < d + 1) en_cnt[k]++;
        if (armed && mode) sw_cnt[k]++;
    endfunction

    // Scoreboard producer: model each edge, queue the expected outputs.
    always @(posedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) model_edge(k);
        e.chk_a  = (en_cnt[0] >= 33);
        e.base_a = 5'((sw_cnt[0] / SWEEP) % 32);
        for (int i = 0; i < 8; i++) e.err_a[i] = sticky[0][i] | (mreg[0][i] & e.chk_a);
        e.chk_b  = (en_cnt[1] >= 129);
        e.base_b = 7'((sw_cnt[1] / SWEEP) % 128);
        for (int i = 0; i < 16; i++) e.err_b[i] = sticky[1][i] | (mreg[1][i] & e.chk_b);
        expq.push_back(e);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("error_a",    32'(err_a),  32'(e.err_a));
            check("checking_a", 32'(chk_a),  32'(e.chk_a));
            check("tap_base_a", 32'(base_a), 32'(e.base_a));
            check("error_b",    32'(err_b),  32'(e.err_b));
            check("checking_b", 32'(chk_b),  32'(e.chk_b));
            check("tap_base_b", 32'(base_b), 32'(e.base_b));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic e, input logic m,
                         input logic [15:0] inj, input int n);
        for (int c = 0; c < n; c++) begin
            rst_n  = r;
            en     = e;
            mode   = m;
            inject = inj;
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic        rm;
        logic        re;
        logic [15:0] ri;

        // Clean fill and fixed-tap checking.
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 4);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 200);
        // Single-cycle faults on lane 0 (addr 0) and lane 2 (addr 6).
        drive(1'b1, 1'b1, 1'b0, 16'h0001, 1);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 20);
        drive(1'b1, 1'b1, 1'b0, 16'h0004, 1);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 20);
        // Simultaneous faults on several lanes.
        drive(1'b1, 1'b1, 1'b0, 16'h2090, 1);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 200);

        // Restart; fault on the first fill edge must never be flagged.
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 2);
        drive(1'b1, 1'b1, 1'b0, 16'h0020, 1);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 300);

        // Sweep mode long enough for both tap bases to wrap; fault mid-sweep.
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 4200);
        drive(1'b1, 1'b1, 1'b1, 16'h0008, 1);
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 4300);

        // Full stall.
        drive(1'b1, 1'b0, 1'b1, 16'h0000, 100);

        // Randomised enable, mode and sparse faults.
        for (int blk = 0; blk < 15; blk++) begin
            rm = 1'($urandom_range(0, 1));
            for (int c = 0; c < 100; c++) begin
                re = ($urandom_range(0, 3) != 0);
                ri = ($urandom_range(0, 149) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
                drive(1'b1, re, rm, ri, 1);
            end
        end

        // Set error[1], then reset mid-check and refill cleanly.
        drive(1'b1, 1'b1, 1'b0, 16'h0002, 1);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 10);
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1);
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 400);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 2);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_srl_shift_checker
`default_nettype wire
